patient_record_queue: RTL

- Downstream consumer of the access controller's writeRegP / writeRegQ strobes.
- Captures the 8-bit key byte into one of two circular FIFOs:
  - P: normal records.
  - Q: priority records.
- Serves reads priority-first, with a one-cycle read latency.
- Flags overflow and underflow so the monitoring logic can report lost or invalid operations.

---
 rtl/patient_record_queue.sv | 129 ++++++++++++
 1 files changed

// File: rtl/patient_record_queue.sv
// Two-FIFO record store fed by edge-detected write strobes; reads are served
// priority-first (Q before P) with one cycle of latency.
module patient_record_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              writeRegP,
  input  logic              writeRegQ,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_req,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              read_src,
  output logic [CNT_W-1:0]  p_count,
  output logic [CNT_W-1:0]  q_count,
  output logic              p_full,
  output logic              q_full,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_p_q [DEPTH];
  logic [DATA_W-1:0] mem_q_q [DEPTH];

  logic [AW-1:0]     p_wptr_q, p_wptr_d, p_rptr_q, p_rptr_d;
  logic [AW-1:0]     q_wptr_q, q_wptr_d, q_rptr_q, q_rptr_d;
  logic [CNT_W-1:0]  p_count_q, p_count_d, q_count_q, q_count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              read_src_q, read_src_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              prev_p_q, prev_q_q;

  logic wr_p, wr_q, p_full_now, q_full_now;
  logic acc_p, acc_q, pop_p, pop_q;

  // Fullness and emptiness are judged on the state before the edge, so a
  // same-edge pop never makes room for a write and a same-edge write never
  // satisfies a read.
  always_comb begin
    wr_p       = writeRegP & ~prev_p_q;
    wr_q       = writeRegQ & ~prev_q_q;
    p_full_now = (p_count_q == FULL_CNT);
    q_full_now = (q_count_q == FULL_CNT);

    acc_q = wr_q & ~q_full_now;
    acc_p = wr_p & ~wr_q & ~p_full_now;
    pop_q = read_req & (q_count_q != '0);
    pop_p = read_req & (q_count_q == '0) & (p_count_q != '0);

    p_wptr_d     = acc_p ? p_wptr_q + AW'(1) : p_wptr_q;
    q_wptr_d     = acc_q ? q_wptr_q + AW'(1) : q_wptr_q;
    p_rptr_d     = pop_p ? p_rptr_q + AW'(1) : p_rptr_q;
    q_rptr_d     = pop_q ? q_rptr_q + AW'(1) : q_rptr_q;
    p_count_d    = p_count_q + CNT_W'(acc_p) - CNT_W'(pop_p);
    q_count_d    = q_count_q + CNT_W'(acc_q) - CNT_W'(pop_q);

    data_out_d   = data_out_q;
    read_src_d   = read_src_q;
    data_valid_d = pop_p | pop_q;
    underflow_d  = read_req & (q_count_q == '0) & (p_count_q == '0);
    if (pop_q) begin
      data_out_d = mem_q_q[q_rptr_q];
      read_src_d = 1'b1;
    end else if (pop_p) begin
      data_out_d = mem_p_q[p_rptr_q];
      read_src_d = 1'b0;
    end

    overflow_d = overflow_q | (wr_p & wr_q) | (wr_q & q_full_now) |
                 (wr_p & ~wr_q & p_full_now);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p_wptr_q     <= '0;
      p_rptr_q     <= '0;
      q_wptr_q     <= '0;
      q_rptr_q     <= '0;
      p_count_q    <= '0;
      q_count_q    <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      read_src_q   <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      prev_p_q     <= 1'b0;
      prev_q_q     <= 1'b0;
    end else begin
      p_wptr_q     <= p_wptr_d;
      p_rptr_q     <= p_rptr_d;
      q_wptr_q     <= q_wptr_d;
      q_rptr_q     <= q_rptr_d;
      p_count_q    <= p_count_d;
      q_count_q    <= q_count_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      read_src_q   <= read_src_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      prev_p_q     <= writeRegP;
      prev_q_q     <= writeRegQ;
    end
  end

  // Record storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (acc_p) mem_p_q[p_wptr_q] <= data_in;
    if (acc_q) mem_q_q[q_wptr_q] <= data_in;
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign read_src   = read_src_q;
  assign p_count    = p_count_q;
  assign q_count    = q_count_q;
  assign p_full     = p_full_now;
  assign q_full     = q_full_now;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule
